sd_init_sequencer: RTL and testbench

Card-identification sequencer directly upstream of the SD command-line controller. It drives the controller's start/index/argument inputs and consumes its finished/timeout/response outputs. It walks the card through CMD0, CMD8, CMD55/ACMD41 (repeated), CMD2 and CMD3, then reports the RCA, CID and capacity class to the host logic.

---
 rtl/sd_pkg.sv | 56 +++++
 rtl/sd_wait_timer.sv | 38 +++
 rtl/sd_init_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_sd_init_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// Shared constants and types for the SD card-identification sequencer.
package sd_pkg;

  localparam logic [5:0]  CMD0_IDX   = 6'd0;
  localparam logic [5:0]  CMD2_IDX   = 6'd2;
  localparam logic [5:0]  CMD3_IDX   = 6'd3;
  localparam logic [5:0]  CMD8_IDX   = 6'd8;
  localparam logic [5:0]  CMD55_IDX  = 6'd55;
  localparam logic [5:0]  ACMD41_IDX = 6'd41;

  localparam logic [11:0] CMD8_CHECK    = 12'h1AA;
  localparam logic [31:0] CMD8_ARG      = 32'h000001AA;
  localparam logic [31:0] ACMD41_ARG_V2 = 32'h40FF8000;
  localparam logic [31:0] ACMD41_ARG_V1 = 32'h00FF8000;

  typedef enum logic [3:0] {
    ERR_NONE           = 4'd0,
    ERR_CMD8_BAD       = 4'd1,
    ERR_CMD55_FAIL     = 4'd2,
    ERR_ACMD41_TIMEOUT = 4'd3,
    ERR_ACMD41_BUSY    = 4'd4,
    ERR_CMD2_FAIL      = 4'd5,
    ERR_CMD3_FAIL      = 4'd6
  } sd_err_e;

  typedef enum logic [3:0] {
    INIT_IDLE  = 4'd0,
    POWERUP    = 4'd1,
    CMD0       = 4'd2,
    CMD8       = 4'd3,
    CMD55      = 4'd4,
    ACMD41     = 4'd5,
    CMD2       = 4'd6,
    CMD3       = 4'd7,
    INIT_DONE  = 4'd8,
    INIT_ERROR = 4'd9
  } sd_state_e;

  // Within a command state: counting the Ncc gap, or waiting for completion.
  typedef enum logic {
    PH_GAP  = 1'b0,
    PH_WAIT = 1'b1
  } sd_phase_e;

  function automatic logic [5:0] cmd_index_of(input sd_state_e st);
    case (st)
      CMD8:    cmd_index_of = CMD8_IDX;
      CMD55:   cmd_index_of = CMD55_IDX;
      ACMD41:  cmd_index_of = ACMD41_IDX;
      CMD2:    cmd_index_of = CMD2_IDX;
      CMD3:    cmd_index_of = CMD3_IDX;
      default: cmd_index_of = CMD0_IDX;
    endcase
  endfunction

endpackage

// File: rtl/sd_wait_timer.sv
// Load/count-down/expire counter shared by the power-up delay and Ncc gaps.
module sd_wait_timer #(
  parameter int WIDTH = 7
) (
  input  logic             sdClock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             expired
);

  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] count_s;

  // Next count: reload, or step down and rest at zero.
  always_comb begin
    count_s = count_r;
    if (load) begin
      count_s = load_value;
    end else if (count_r != {WIDTH{1'b0}}) begin
      count_s = count_r - {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count_s = count_r;
    end
  end

  // Counter and registered expiry flag.
  always_ff @(posedge sdClock or posedge reset) begin
    if (reset) begin
      count_r <= {WIDTH{1'b0}};
      expired <= 1'b1;
    end else begin
      count_r <= count_s;
      expired <= (count_s == {WIDTH{1'b0}});
    end
  end

endmodule

// File: rtl/sd_init_sequencer.sv
// SD card-identification sequencer: CMD0, CMD8, CMD55/ACMD41 loop, CMD2, CMD3,
// driving the command-line controller and reporting RCA, CID and capacity class.
module sd_init_sequencer
  import sd_pkg::*;
#(
  parameter int POWERUP_CYCLES = 80,
  parameter int GAP_CYCLES     = 8,
  parameter int ACMD41_RETRIES = 1000
) (
  input  logic         sdClock,
  input  logic         reset,
  input  logic         initStart,
  output logic         cmdStart,
  output logic [5:0]   cmdIndex,
  output logic [31:0]  cmdArgument,
  input  logic         cmdFinished,
  input  logic         cmdTimeout,
  input  logic [5:0]   cmdResponseIndex,
  input  logic [119:0] cmdResponseArgument,
  output logic         busy,
  output logic         initDone,
  output logic         initError,
  output logic [3:0]   errorCode,
  output logic [15:0]  rca,
  output logic [119:0] cid,
  output logic         highCapacity
);

  localparam int TMR_MAX = (POWERUP_CYCLES > GAP_CYCLES) ? POWERUP_CYCLES : GAP_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int RTY_W   = $clog2(ACMD41_RETRIES + 1);
  // Timer reaches zero one cycle before cmdStart is registered, hence the -1.
  localparam logic [TMR_W-1:0] POWERUP_LOAD = TMR_W'(POWERUP_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD     = TMR_W'(GAP_CYCLES - 1);
  localparam logic [RTY_W-1:0] RETRY_LIMIT  = RTY_W'(ACMD41_RETRIES);

  sd_state_e      state_r, state_s, adv_state_s;
  sd_phase_e      phase_r, phase_s;
  sd_err_e        err_code_r, err_code_s, fail_code_s;
  logic           cmd_start_r, cmd_start_s;
  logic [5:0]     cmd_index_r, cmd_index_s;
  logic [31:0]    cmd_arg_r, cmd_arg_s;
  logic           busy_r, busy_s, done_r, done_s, error_r, error_s;
  logic [15:0]    rca_r, rca_s;
  logic [119:0]   cid_r, cid_s;
  logic           high_cap_r, high_cap_s, sd_v2_r, sd_v2_s, armed_r;
  logic [RTY_W-1:0] retry_r, retry_s;
  logic           tmr_load_s, tmr_expired_s, issue_s, adv_s, fail_s, finish_s;
  logic [TMR_W-1:0] tmr_value_s;
  logic [31:0]    rsp_arg_s;

  assign rsp_arg_s = cmdResponseArgument[31:0];
  // A completion during the issue cycle cannot be legitimate, so it is dropped.
  assign finish_s  = cmdFinished & ~cmd_start_r;

  sd_wait_timer #(.WIDTH(TMR_W)) u_timer (
    .sdClock    (sdClock),
    .reset      (reset),
    .load       (tmr_load_s),
    .load_value (tmr_value_s),
    .expired    (tmr_expired_s)
  );

  // Next-state, response evaluation and command issue.
  always_comb begin
    state_s = state_r;  phase_s = phase_r;  err_code_s = err_code_r;
    cmd_start_s = 1'b0; cmd_index_s = cmd_index_r; cmd_arg_s = cmd_arg_r;
    busy_s = busy_r;    done_s = done_r;    error_s = error_r;
    rca_s = rca_r;      cid_s = cid_r;      high_cap_s = high_cap_r;
    sd_v2_s = sd_v2_r;  retry_s = retry_r;
    tmr_load_s = 1'b0;  tmr_value_s = GAP_LOAD;
    issue_s = 1'b0;     adv_s = 1'b0;       adv_state_s = state_r;
    fail_s = 1'b0;      fail_code_s = ERR_NONE;

    case (state_r)
      INIT_IDLE, INIT_DONE, INIT_ERROR: begin
        if (initStart && armed_r) begin
          state_s = POWERUP;  busy_s = 1'b1;  done_s = 1'b0;  error_s = 1'b0;
          err_code_s = ERR_NONE;  rca_s = 16'h0000;  cid_s = 120'h0;
          high_cap_s = 1'b0;  sd_v2_s = 1'b0;  retry_s = {RTY_W{1'b0}};
          tmr_load_s = 1'b1;  tmr_value_s = POWERUP_LOAD;
        end else begin
          state_s = state_r;
        end
      end
      POWERUP: begin
        if (tmr_expired_s) begin
          state_s = CMD0;
          issue_s = 1'b1;
        end else begin
          issue_s = 1'b0;
        end
      end
      CMD0, CMD8, CMD55, ACMD41, CMD2, CMD3: begin
        if (phase_r == PH_GAP) begin
          issue_s = tmr_expired_s;
        end else if (finish_s) begin
          case (state_r)
            CMD0: begin
              adv_s = 1'b1;  adv_state_s = CMD8;
            end
            CMD8: begin
              if (cmdTimeout) begin
                sd_v2_s = 1'b0;  adv_s = 1'b1;  adv_state_s = CMD55;
              end else if (cmdResponseIndex == CMD8_IDX && rsp_arg_s[11:0] == CMD8_CHECK) begin
                sd_v2_s = 1'b1;  adv_s = 1'b1;  adv_state_s = CMD55;
              end else begin
                fail_s = 1'b1;  fail_code_s = ERR_CMD8_BAD;
              end
            end
            CMD55: begin
              if (!cmdTimeout && cmdResponseIndex == CMD55_IDX) begin
                adv_s = 1'b1;  adv_state_s = ACMD41;
              end else begin
                fail_s = 1'b1;  fail_code_s = ERR_CMD55_FAIL;
              end
            end
            ACMD41: begin
              if (cmdTimeout) begin
                fail_s = 1'b1;  fail_code_s = ERR_ACMD41_TIMEOUT;
              end else if (rsp_arg_s[31]) begin
                high_cap_s = rsp_arg_s[30];  adv_s = 1'b1;  adv_state_s = CMD2;
              end else begin
                retry_s = retry_r + {{(RTY_W-1){1'b0}}, 1'b1};
                if (retry_s == RETRY_LIMIT) begin
                  fail_s = 1'b1;  fail_code_s = ERR_ACMD41_BUSY;
                end else begin
                  adv_s = 1'b1;  adv_state_s = CMD55;
                end
              end
            end
            CMD2: begin
              if (cmdTimeout) begin
                fail_s = 1'b1;  fail_code_s = ERR_CMD2_FAIL;
              end else begin
                cid_s = cmdResponseArgument;  adv_s = 1'b1;  adv_state_s = CMD3;
              end
            end
            CMD3: begin
              if (!cmdTimeout && cmdResponseIndex == CMD3_IDX) begin
                rca_s = rsp_arg_s[31:16];  adv_s = 1'b1;  adv_state_s = INIT_DONE;
              end else begin
                fail_s = 1'b1;  fail_code_s = ERR_CMD3_FAIL;
              end
            end
            default: begin
              fail_s = 1'b0;
            end
          endcase
        end else begin
          issue_s = 1'b0;
        end
      end
      default: begin
        state_s = INIT_IDLE;
      end
    endcase

    if (fail_s) begin
      state_s = INIT_ERROR;  busy_s = 1'b0;  error_s = 1'b1;  err_code_s = fail_code_s;
    end else if (adv_s) begin
      state_s = adv_state_s;  phase_s = PH_GAP;
      tmr_load_s = 1'b1;  tmr_value_s = GAP_LOAD;
      if (adv_state_s == INIT_DONE) begin
        done_s = 1'b1;  busy_s = 1'b0;
      end else begin
        done_s = done_r;
      end
    end else begin
      state_s = state_s;
    end

    if (issue_s) begin
      phase_s = PH_WAIT;  cmd_start_s = 1'b1;  cmd_index_s = cmd_index_of(state_s);
      case (state_s)
        CMD8:    cmd_arg_s = CMD8_ARG;
        CMD55:   cmd_arg_s = {rca_r, 16'h0000};
        ACMD41:  cmd_arg_s = sd_v2_r ? ACMD41_ARG_V2 : ACMD41_ARG_V1;
        default: cmd_arg_s = 32'h0000_0000;
      endcase
    end else begin
      cmd_start_s = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge sdClock or posedge reset) begin
    if (reset) begin
      state_r <= INIT_IDLE;  phase_r <= PH_GAP;  err_code_r <= ERR_NONE;
      cmd_start_r <= 1'b0;   cmd_index_r <= 6'd0;  cmd_arg_r <= 32'h0000_0000;
      busy_r <= 1'b0;  done_r <= 1'b0;  error_r <= 1'b0;
      rca_r <= 16'h0000;  cid_r <= 120'h0;  high_cap_r <= 1'b0;
      sd_v2_r <= 1'b0;  retry_r <= {RTY_W{1'b0}};  armed_r <= 1'b0;
    end else begin
      state_r <= state_s;  phase_r <= phase_s;  err_code_r <= err_code_s;
      cmd_start_r <= cmd_start_s;  cmd_index_r <= cmd_index_s;  cmd_arg_r <= cmd_arg_s;
      busy_r <= busy_s;  done_r <= done_s;  error_r <= error_s;
      rca_r <= rca_s;  cid_r <= cid_s;  high_cap_r <= high_cap_s;
      sd_v2_r <= sd_v2_s;  retry_r <= retry_s;  armed_r <= 1'b1;
    end
  end

  assign cmdStart     = cmd_start_r;
  assign cmdIndex     = cmd_index_r;
  assign cmdArgument  = cmd_arg_r;
  assign busy         = busy_r;
  assign initDone     = done_r;
  assign initError    = error_r;
  assign errorCode    = err_code_r;
  assign rca          = rca_r;
  assign cid          = cid_r;
  assign highCapacity = high_cap_r;

endmodule

// File: tb/tb_sd_init_sequencer.sv
// Directed bench for sd_init_sequencer with a behavioural card/controller responder.
module tb_sd_init_sequencer;

  localparam int P = 80;
  localparam int G = 8;
  localparam int R = 4;
  localparam logic [119:0] CID_VAL = 120'h0123456789ABCDEFFEDCBA98765432;

  logic         sdClock = 1'b0;
  logic         reset, initStart, cmdStart, cmdFinished, cmdTimeout;
  logic [5:0]   cmdIndex, cmdResponseIndex;
  logic [31:0]  cmdArgument;
  logic [119:0] cmdResponseArgument, cid;
  logic         busy, initDone, initError, highCapacity;
  logic [3:0]   errorCode;
  logic [15:0]  rca;

  sd_init_sequencer #(.POWERUP_CYCLES(P), .GAP_CYCLES(G), .ACMD41_RETRIES(R)) dut (
    .sdClock(sdClock), .reset(reset), .initStart(initStart),
    .cmdStart(cmdStart), .cmdIndex(cmdIndex), .cmdArgument(cmdArgument),
    .cmdFinished(cmdFinished), .cmdTimeout(cmdTimeout),
    .cmdResponseIndex(cmdResponseIndex), .cmdResponseArgument(cmdResponseArgument),
    .busy(busy), .initDone(initDone), .initError(initError), .errorCode(errorCode),
    .rca(rca), .cid(cid), .highCapacity(highCapacity)
  );

  always #5 sdClock = ~sdClock;

  int cyc = 0;
  always @(posedge sdClock) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  int cmd8_mode, busy_max, busy_cnt, starts, acm_cnt, start_cyc, fin_cyc, s0, n;
  logic [31:0] r3_ready, r6_arg, acm_arg;
  bit saw_cmd2, first_pending, fin_valid;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_cmdStart"}, 128'(cmdStart), 128'(0));
    chk({tag, "_cmdIndex"}, 128'(cmdIndex), 128'(0));
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_initDone"}, 128'(initDone), 128'(0));
    chk({tag, "_initError"}, 128'(initError), 128'(0));
    chk({tag, "_errorCode"}, 128'(errorCode), 128'(0));
    chk({tag, "_rca"}, 128'(rca), 128'(0));
    chk({tag, "_cid"}, 128'(cid), 128'(0));
    chk({tag, "_hc"}, 128'(highCapacity), 128'(0));
  endtask

  task automatic pulse_start();
    @(negedge sdClock);
    initStart = 1'b1;  start_cyc = cyc;  first_pending = 1'b1;  fin_valid = 1'b0;
    @(negedge sdClock);
    initStart = 1'b0;
  endtask

  task automatic wait_term(input string tag);
    int k;
    k = 0;
    while (!(initDone === 1'b1 || initError === 1'b1) && k < 5000) begin
      @(negedge sdClock);
      k++;
    end
    chk(tag, 128'(k < 5000), 128'(1));
  endtask

  task automatic respond(input logic [5:0] idx);
    cmdFinished = 1'b1;  cmdTimeout = 1'b0;
    cmdResponseIndex = idx;  cmdResponseArgument = 120'h0;
    case (idx)
      6'd0: cmdTimeout = 1'b1;
      6'd8: begin
        if (cmd8_mode == 1) cmdTimeout = 1'b1;
        else cmdResponseArgument = (cmd8_mode == 2) ? 120'h1AB : 120'h1AA;
      end
      6'd55: cmdResponseArgument = 120'h120;
      6'd41: begin
        cmdResponseIndex = 6'h3F;
        if (busy_cnt < busy_max) begin
          busy_cnt++;
          cmdResponseArgument = 120'h00FF8000;
        end else begin
          cmdResponseArgument = {88'h0, r3_ready};
        end
      end
      6'd2: begin cmdResponseIndex = 6'h3F; cmdResponseArgument = CID_VAL; end
      6'd3: cmdResponseArgument = {88'h0, r6_arg};
      default: cmdTimeout = 1'b1;
    endcase
  endtask

  // Card/controller responder and cmdStart monitor, acting on the falling edge.
  initial begin
    bit pend;
    int lat;
    logic [5:0] ridx;
    pend = 1'b0;  lat = 0;  ridx = 6'd0;
    cmdFinished = 1'b0;  cmdTimeout = 1'b0;  cmdResponseIndex = 6'd0;  cmdResponseArgument = 120'h0;
    forever begin
      @(negedge sdClock);
      if (cmdStart === 1'b1) begin
        starts++;
        if (first_pending) begin
          chk("powerup_gap", 128'(cyc - start_cyc), 128'(P + 1));
          first_pending = 1'b0;
        end else if (fin_valid) begin
          chk("ncc_gap", 128'(cyc - fin_cyc), 128'(G + 1));
        end
        fin_valid = 1'b0;
        if (cmdIndex == 6'd41) begin acm_cnt++; acm_arg = cmdArgument; end
        if (cmdIndex == 6'd2) saw_cmd2 = 1'b1;
      end
      cmdFinished = 1'b0;  cmdTimeout = 1'b0;
      if (reset) begin
        pend = 1'b0;
      end else if (cmdStart === 1'b1) begin
        pend = 1'b1;  lat = 4;  ridx = cmdIndex;
      end else if (pend) begin
        lat--;
        if (lat == 0) begin
          pend = 1'b0;
          respond(ridx);
          fin_cyc = cyc;  fin_valid = 1'b1;
        end
      end
    end
  end

  initial begin
    reset = 1'b1;  initStart = 1'b0;
    cmd8_mode = 0;  busy_max = 0;  busy_cnt = 0;  starts = 0;  acm_cnt = 0;
    r3_ready = 32'h0;  r6_arg = 32'h0;  acm_arg = 32'h0;
    saw_cmd2 = 1'b0;  first_pending = 1'b0;  fin_valid = 1'b0;
    repeat (3) @(negedge sdClock);
    check_zero("por");

    // initStart in the same cycle as reset release is ignored
    @(negedge sdClock);
    reset = 1'b0;  initStart = 1'b1;
    @(negedge sdClock);
    initStart = 1'b0;
    @(negedge sdClock);
    chk("release_start_busy", 128'(busy), 128'(0));
    chk("release_start_nocmd", 128'(starts), 128'(0));

    // SDHC card: two busy R3s, then ready with CCS; extra initStart while busy
    busy_max = 2;  busy_cnt = 0;  r3_ready = 32'hC0FF8000;  r6_arg = 32'h12340000;  acm_cnt = 0;
    pulse_start();
    chk("sdhc_busy", 128'(busy), 128'(1));
    repeat (30) @(negedge sdClock);
    initStart = 1'b1;
    @(negedge sdClock);
    initStart = 1'b0;
    wait_term("sdhc_term");
    chk("sdhc_done", 128'(initDone), 128'(1));
    chk("sdhc_err", 128'(initError), 128'(0));
    chk("sdhc_code", 128'(errorCode), 128'(0));
    chk("sdhc_busy_end", 128'(busy), 128'(0));
    chk("sdhc_rca", 128'(rca), 128'(16'h1234));
    chk("sdhc_cid", 128'(cid), 128'(CID_VAL));
    chk("sdhc_hc", 128'(highCapacity), 128'(1));
    chk("sdhc_acmd_count", 128'(acm_cnt), 128'(3));
    chk("sdhc_acmd_arg", 128'(acm_arg), 128'(32'h40FF8000));

    // v1 card: CMD8 times out; restart clears results
    cmd8_mode = 1;  busy_max = 0;  busy_cnt = 0;  r3_ready = 32'h80FF8000;  r6_arg = 32'hBEEF0000;  acm_cnt = 0;
    pulse_start();
    chk("restart_rca_clr", 128'(rca), 128'(0));
    chk("restart_cid_clr", 128'(cid), 128'(0));
    chk("restart_done_clr", 128'(initDone), 128'(0));
    chk("restart_busy", 128'(busy), 128'(1));
    wait_term("v1_term");
    chk("v1_done", 128'(initDone), 128'(1));
    chk("v1_hc", 128'(highCapacity), 128'(0));
    chk("v1_acmd_arg", 128'(acm_arg), 128'(32'h00FF8000));
    chk("v1_acmd_count", 128'(acm_cnt), 128'(1));
    chk("v1_rca", 128'(rca), 128'(16'hBEEF));

    // CMD8 echo mismatch
    cmd8_mode = 2;
    pulse_start();
    wait_term("cmd8bad_term");
    chk("cmd8bad_err", 128'(initError), 128'(1));
    chk("cmd8bad_code", 128'(errorCode), 128'(1));
    chk("cmd8bad_done", 128'(initDone), 128'(0));
    chk("cmd8bad_busy", 128'(busy), 128'(0));
    s0 = starts;
    repeat (50) @(negedge sdClock);
    chk("cmd8bad_quiet", 128'(starts), 128'(s0));

    // Card never leaves busy: retry limit
    cmd8_mode = 0;  busy_max = 1000;  busy_cnt = 0;  acm_cnt = 0;
    pulse_start();
    wait_term("retry_term");
    chk("retry_err", 128'(initError), 128'(1));
    chk("retry_code", 128'(errorCode), 128'(4));
    chk("retry_acmd_count", 128'(acm_cnt), 128'(R));

    // Reset during CMD2 wait, then a full replay
    busy_max = 0;  busy_cnt = 0;  r3_ready = 32'hC0FF8000;  r6_arg = 32'h12340000;  saw_cmd2 = 1'b0;
    pulse_start();
    n = 0;
    while (!saw_cmd2 && n < 5000) begin
      @(negedge sdClock);
      n++;
    end
    chk("cmd2_reached", 128'(n < 5000), 128'(1));
    repeat (2) @(negedge sdClock);
    #2 reset = 1'b1;
    #1 check_zero("async_rst");
    s0 = starts;
    repeat (10) @(negedge sdClock);
    chk("rst_quiet", 128'(starts), 128'(s0));
    reset = 1'b0;
    repeat (3) @(negedge sdClock);
    chk("post_rst_idle", 128'(busy), 128'(0));
    chk("post_rst_quiet", 128'(starts), 128'(s0));
    pulse_start();
    wait_term("replay_term");
    chk("replay_done", 128'(initDone), 128'(1));
    chk("replay_rca", 128'(rca), 128'(16'h1234));
    chk("replay_hc", 128'(highCapacity), 128'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
